// File: rtl/i2c_pkg.sv
// Shared command codes, sequencer states and the per-step command decode
// used by the i2c master, the register-transaction sequencer and its bench.
package i2c_pkg;

   typedef enum logic [2:0] {
      CMD_START   = 3'b000,
      CMD_WR      = 3'b001,
      CMD_RD      = 3'b010,
      CMD_STOP    = 3'b011,
      CMD_RESTART = 3'b100
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_RESP
   } seq_state_e;

   localparam int         MAX_STEPS   = 7;
   localparam logic [7:0] RD_LAST_DIN = 8'h01;

   typedef logic [$clog2(MAX_STEPS)-1:0] step_idx_t;

   localparam step_idx_t WR_STOP_STEP = step_idx_t'(4);
   localparam step_idx_t RD_STOP_STEP = step_idx_t'(MAX_STEPS - 1);

   typedef struct packed {
      cmd_e       cmd;
      logic [7:0] din;
      logic       is_last;
   } step_t;

   // Anything past the data phase of the active list decodes to STOP.
   function automatic step_t step_decode(input step_idx_t  step,
                                         input logic       rnw,
                                         input logic [6:0] addr,
                                         input logic [7:0] rgi,
                                         input logic [7:0] wdata);
      step_t s;
      s = '{cmd: CMD_STOP, din: 8'h00, is_last: 1'b1};
      case (step)
         step_idx_t'(0): s = '{cmd: CMD_START, din: 8'h00, is_last: 1'b0};
         step_idx_t'(1): s = '{cmd: CMD_WR, din: {addr, 1'b0}, is_last: 1'b0};
         step_idx_t'(2): s = '{cmd: CMD_WR, din: rgi, is_last: 1'b0};
         step_idx_t'(3): begin
            if (rnw) s = '{cmd: CMD_RESTART, din: 8'h00, is_last: 1'b0};
            else     s = '{cmd: CMD_WR, din: wdata, is_last: 1'b0};
         end
         step_idx_t'(4): if (rnw) s = '{cmd: CMD_WR, din: {addr, 1'b1}, is_last: 1'b0};
         step_idx_t'(5): if (rnw) s = '{cmd: CMD_RD, din: RD_LAST_DIN, is_last: 1'b0};
         default: ;
      endcase
      return s;
   endfunction

   function automatic step_idx_t stop_step(input logic rnw);
      return rnw ? RD_STOP_STEP : WR_STOP_STEP;
   endfunction

endpackage

// File: rtl/i2c_txn_seq.sv
// Register read/write sequencer: walks one request through START..STOP on the
// i2c master's command port, checks slave ACKs and returns one response.
module i2c_txn_seq
   import i2c_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4096,
   parameter int TO_W        = 13
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rnw_i,
   input  logic [6:0] req_addr_i,
   input  logic [7:0] req_reg_i,
   input  logic [7:0] req_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_nack_o,
   output logic       rsp_tout_o,
   output logic [2:0] m_cmd_o,
   output logic [7:0] m_din_o,
   output logic       m_wr_i2c_o,
   input  logic       m_ready_i,
   input  logic       m_ack_i,
   input  logic [7:0] m_dout_i
);

   seq_state_e      state, state_nxt;
   step_idx_t       step, step_nxt;
   logic [TO_W-1:0] to_cnt;
   logic            rnw_q;
   logic [6:0]      addr_q;
   logic [7:0]      reg_q, wdata_q, rdata_q, din_q;
   logic            nack_q, tout_q;
   cmd_e            cmd_q;
   step_t           cur;
   logic            accept, issue, done, nack_hit, expire;

   assign cur      = step_decode(step, rnw_q, addr_q, reg_q, wdata_q);
   assign accept   = (state == S_IDLE) && req_valid_i && req_ready_o;
   assign issue    = (state == S_ISSUE) && m_ready_i;
   assign done     = (state == S_WAIT_DONE) && m_ready_i;
   assign nack_hit = done && (cmd_q == CMD_WR) && m_ack_i;
   // Expiry only counts while still waiting; a transition on the last count wins.
   assign expire   = (((state == S_WAIT_BUSY) && m_ready_i) ||
                      ((state == S_WAIT_DONE) && !m_ready_i)) &&
                     (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      case (state)
         S_IDLE: if (accept) begin
            state_nxt = S_ISSUE;
            step_nxt  = '0;
         end
         S_ISSUE: if (m_ready_i) state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (expire)          state_nxt = S_RESP;
            else if (!m_ready_i) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (expire) state_nxt = S_RESP;
            else if (m_ready_i) begin
               if (cur.is_last) state_nxt = S_RESP;
               else begin
                  state_nxt = S_ISSUE;
                  step_nxt  = nack_hit ? stop_step(rnw_q) : step + step_idx_t'(1);
               end
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         step        <= '0;
         to_cnt      <= '0;
         req_ready_o <= 1'b0;
         rnw_q       <= 1'b0;
         addr_q      <= '0;
         reg_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         nack_q      <= 1'b0;
         tout_q      <= 1'b0;
         cmd_q       <= CMD_START;
         din_q       <= '0;
      end else begin
         state       <= state_nxt;
         step        <= step_nxt;
         req_ready_o <= (state == S_IDLE) && !accept;
         if (accept) begin
            rnw_q   <= req_rnw_i;
            addr_q  <= req_addr_i;
            reg_q   <= req_reg_i;
            wdata_q <= req_wdata_i;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            tout_q  <= 1'b0;
         end
         if (issue) begin
            cmd_q  <= cur.cmd;
            din_q  <= cur.din;
            to_cnt <= '0;
         end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (done && cmd_q == CMD_RD) rdata_q <= m_dout_i;
         if (nack_hit)                nack_q  <= 1'b1;
         if (expire)                  tout_q  <= 1'b1;
      end
   end

   // The strobe cycle presents the new step directly; afterwards the register holds it.
   assign m_wr_i2c_o  = issue;
   assign m_cmd_o     = issue ? cur.cmd : cmd_q;
   assign m_din_o     = issue ? cur.din : din_q;

   assign rsp_valid_o = (state == S_RESP);
   assign rsp_rdata_o = (rsp_valid_o && !nack_q && !tout_q) ? rdata_q : 8'h00;
   assign rsp_nack_o  = rsp_valid_o && nack_q;
   assign rsp_tout_o  = rsp_valid_o && tout_q;

endmodule
